gollmann_cascade_param: RTL and testbench
=========================================

GOLLMANN_CASCADE_PARAM -- requirements
Module: gollmann_cascade_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32: LFSR length per stage, 2..64.
REQ-002 SHALL have parameter STAGES, default 3: number of cascaded LFSR stages, 1..16.
REQ-003 SHALL have parameter TAP_MASK, default 32'h80200003: WIDTH-bit feedback tap mask, shared by all stages.
REQ-004 SHALL have parameter SEED, default 1: base reset seed, WIDTH bits.
REQ-005 SHALL have parameter OUT_W, default 8: packed output word width, 1..64.
REQ-006 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port en, input, 1: request to advance the generator one bit.
REQ-009 SHALL have port restart, input, 1: synchronous reload of reset seeds and clear of the packer.
REQ-010 SHALL have port seed_we, input, 1: seed write strobe.
REQ-011 SHALL have port seed_sel, input, SEL_W = max(1, clog2(STAGES)): target stage index.
REQ-012 SHALL have port seed_data, input, WIDTH: seed value.
REQ-013 SHALL have port gc_bit, output, 1: current cascade output bit (combinational from state).
REQ-014 SHALL have port stage_msb, output, STAGES: MSB of each stage, bit k = stage k.
REQ-015 SHALL have port out_data, output, OUT_W: packed word, first generated bit in the MSB.
REQ-016 SHALL have port out_valid, output, 1: out_data holds an unconsumed word.
REQ-017 SHALL have port out_ready, input, 1: consumer accepts out_data when out_valid=1.

Function
REQ-018 SHALL implement each stage as a Fibonacci LFSR s_k stepping s_k <= {s_k[WIDTH-2:0], XOR-reduce(s_k & TAP_MASK)}; m_k = s_k[WIDTH-1].
REQ-019 SHALL form the cascade chain x_0 = ~m_0 and x_k = x_(k-1) ^ m_k, with gc_bit = x_(STAGES-1).
REQ-020 SHALL, on each advance, step stage 0 and step stage k (k>=1) only if x_(k-1)=1, with all x evaluated on pre-step state; no gated or derived clocks.
REQ-021 SHALL define advance = en & ~restart & ~seed_we & ~stall.
REQ-022 SHALL define stall = (bit_cnt == OUT_W-1) & out_valid & ~out_ready.
REQ-023 SHALL, on advance, shift gc_bit into the packer LSB and increment bit_cnt; on the OUT_W-th bit, load out_data with the complete word, set out_valid=1, and set bit_cnt=0.
REQ-024 SHALL clear out_valid when out_valid & out_ready and no word completes that cycle; a completing word with out_ready=1 replaces the old word in the same cycle (zero-bubble).
REQ-025 SHALL, on seed_we, load the stage selected by seed_sel with seed_data; if seed_data=0, load 1 (lock-up guard); ignore seed_sel >= STAGES; no advance that cycle; packer unchanged.
REQ-026 SHALL, on restart, reload every stage to its reset seed, clear bit_cnt and the packer, and set out_valid=0; priority is restart > seed_we > advance.
REQ-027 SHALL hold all state when en=0, stalled, or idle; out_valid/out_data stable while out_valid=1 & out_ready=0.

Reset
REQ-028 SHALL, while rst=1, set stage k to SEED ^ k (1 if zero), bit_cnt=0, packer=0, out_data=0, out_valid=0.
REQ-029 SHALL apply reset asynchronously; deassertion is synchronised by the integrator; first advance possible on the first clk edge with rst=0.

Verification
REQ-030 SHALL cover reset: WIDTH=4, TAP_MASK=4'b1100, STAGES=1, SEED=1 -> s_0=0001, gc_bit=1, out_valid=0, stage_msb=0.
REQ-031 SHALL cover the sequence: same config, OUT_W=8, en=1, out_ready=1 -> out_valid pulses after 8 advances with out_data=8'hEC; stage 0 returns to 0001 after 15 advances.
REQ-032 SHALL cover backpressure: out_ready=0 with en=1 -> after 15 advances bit_cnt=7, advance stalls, out_data held at 8'hEC; raising out_ready completes the next word in the same cycle.
REQ-033 SHALL cover the zero-seed guard: seed_we=1, seed_sel=0, seed_data=0 -> stage 0 = 0001; same cycle with en=1 -> no advance.
REQ-034 SHALL cover the cascade: default parameters with stage 0 seeded so m_0=1 -> x_0=0, stage 1 holds while stage 0 steps; with m_0=0, stage 1 steps.
REQ-035 SHALL cover restart mid-word: restart after 5 advances with en=1 -> state equals post-reset, no advance, out_valid=0.

Source files
------------

// File: rtl/gollmann_cascade_param.sv
// -----------------------------------------------------------------------------
// gollmann_cascade_param
//
// Gollmann cascade pseudo-random bit generator with an output word packer.
// STAGES identical Fibonacci LFSRs are chained. Stage 0 steps on every
// advance. Each later stage steps only when the chain bit from the stage below
// is 1. The cascade output bit is shifted into a packer. Every OUT_W bits, the
// packer presents one word through a valid/ready handshake.
//
// Parameters
//   WIDTH     LFSR length per stage (2..64)
//   STAGES    number of cascaded stages (1..16)
//   TAP_MASK  feedback tap mask shared by all stages
//   SEED      base reset seed; stage k resets to SEED ^ k, or 1 if that is 0
//   OUT_W     packed output word width (1..64)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   en         request to advance the generator by one bit
//   restart    synchronous reload of the reset seeds and clear of the packer
//   seed_we    seed write strobe
//   seed_sel   target stage of a seed write
//   seed_data  seed value to write (0 is replaced by 1)
//   gc_bit     current cascade output bit
//   stage_msb  MSB of each stage; bit k belongs to stage k
//   out_data   packed word; the first generated bit is in the MSB
//   out_valid  out_data holds a word that has not been consumed
//   out_ready  consumer accepts out_data while out_valid is 1
// -----------------------------------------------------------------------------
module gollmann_cascade_param #(
   parameter int                WIDTH    = 32,
   parameter int                STAGES   = 3,
   parameter logic [WIDTH-1:0]  TAP_MASK = WIDTH'(32'h80200003),
   parameter logic [WIDTH-1:0]  SEED     = WIDTH'(1),
   parameter int                OUT_W    = 8,
   localparam int               SEL_W    = (STAGES > 1) ? $clog2(STAGES) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              restart,
   input  logic              seed_we,
   input  logic [SEL_W-1:0]  seed_sel,
   input  logic [WIDTH-1:0]  seed_data,
   output logic              gc_bit,
   output logic [STAGES-1:0] stage_msb,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

   // Reset seed of stage k. An all-zero state would lock up the LFSR,
   // so a zero result is replaced by 1.
   function automatic logic [WIDTH-1:0] seed_for(input int k);
      logic [WIDTH-1:0] v;
      v = SEED ^ WIDTH'(k);
      if (v == '0)
         v = WIDTH'(1);
      return v;
   endfunction

   logic [STAGES-1:0] chain_x;    // x_k, computed from the state before the step
   logic [STAGES-1:0] step_en;    // stage k may step on this advance
   logic              advance;
   logic              stall;
   logic              last_bit;
   logic              complete;
   logic [OUT_W-1:0]  shifted;

   logic [OUT_W-1:0]  pack_reg;
   logic [CNT_W-1:0]  bit_cnt_reg;
   logic [OUT_W-1:0]  out_data_reg;
   logic              out_valid_reg;

   // Chain bits: x_0 = ~m_0 and x_k = x_(k-1) ^ m_k.
   // Stage k steps only when x_(k-1) is 1. Stage 0 always steps.
   always_comb begin
      chain_x    = '0;
      step_en    = '0;
      chain_x[0] = ~stage_msb[0];
      step_en[0] = 1'b1;
      for (int k = 1; k < STAGES; k++) begin
         chain_x[k] = chain_x[k-1] ^ stage_msb[k];
         step_en[k] = chain_x[k-1];
      end
   end

   assign gc_bit = chain_x[STAGES-1];

   // A completed word cannot be handed over while the previous word is still
   // waiting. Only the final bit of a word has to wait.
   assign last_bit = (bit_cnt_reg == CNT_W'(OUT_W - 1));
   assign stall    = last_bit & out_valid_reg & ~out_ready;
   assign advance  = en & ~restart & ~seed_we & ~stall;
   assign complete = advance & last_bit;

   generate
      if (OUT_W == 1) begin : g_shift_1
         assign shifted = gc_bit;
      end else begin : g_shift_n
         assign shifted = {pack_reg[OUT_W-2:0], gc_bit};
      end
   endgenerate

   // One register per stage. All stages share the clock; stepping is
   // qualified by an enable.
   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         localparam logic [WIDTH-1:0] RST_SEED = seed_for(gi);
         logic [WIDTH-1:0] state_reg;
         logic             seed_hit;

         // Any seed_sel at or above STAGES matches no stage and is ignored.
         assign seed_hit     = seed_we & (seed_sel == SEL_W'(gi));
         assign stage_msb[gi] = state_reg[WIDTH-1];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               state_reg <= RST_SEED;
            end else if (restart) begin
               state_reg <= RST_SEED;
            end else if (seed_we) begin
               if (seed_hit)
                  state_reg <= (seed_data == '0) ? WIDTH'(1) : seed_data;
            end else if (advance && step_en[gi]) begin
               state_reg <= {state_reg[WIDTH-2:0], ^(state_reg & TAP_MASK)};
            end
         end
      end
   endgenerate

   // Packer and output handshake. A word that completes while the consumer
   // takes the previous word replaces it in the same cycle, so no bubble occurs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pack_reg      <= '0;
         bit_cnt_reg   <= '0;
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
      end else if (restart) begin
         pack_reg      <= '0;
         bit_cnt_reg   <= '0;
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         if (advance) begin
            pack_reg    <= shifted;
            bit_cnt_reg <= last_bit ? '0 : bit_cnt_reg + CNT_W'(1);
         end
         if (complete) begin
            out_data_reg  <= shifted;
            out_valid_reg <= 1'b1;
         end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

   assign out_data  = out_data_reg;
   assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_gollmann_cascade_param.sv
// -----------------------------------------------------------------------------
// tb_gollmann_cascade_param
//
// Directed testbench for gollmann_cascade_param. It uses two instances:
//   u_small : WIDTH=4, STAGES=1, TAP_MASK=4'b1100, SEED=1, OUT_W=8.
//             Its 15-state sequence and cascade bits are tabulated below.
//   u_dflt  : default parameters, used for the cascade step/hold behaviour.
// Inputs are driven and outputs are checked on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_gollmann_cascade_param;

   logic clk = 1'b0;
   logic rst;

   // small instance signals
   logic       s_en, s_restart, s_seed_we, s_out_ready;
   logic [0:0] s_seed_sel;
   logic [3:0] s_seed_data;
   logic       s_gc;
   logic [0:0] s_msb;
   logic [7:0] s_out_data;
   logic       s_out_valid;

   // default instance signals
   logic        d_en, d_restart, d_seed_we, d_out_ready;
   logic [1:0]  d_seed_sel;
   logic [31:0] d_seed_data;
   logic        d_gc;
   logic [2:0]  d_msb;
   logic [7:0]  d_out_data;
   logic        d_out_valid;

   int n_vec = 0;
   int n_err = 0;
   int sidx  = 0;

   // gc_bit of the 4-bit LFSR (taps 1100) for states
   // 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8. Here gc_bit = ~msb.
   logic gc_tab [15] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                         1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

   always #5 clk = ~clk;

   gollmann_cascade_param #(
      .WIDTH(4), .STAGES(1), .TAP_MASK(4'b1100), .SEED(4'd1), .OUT_W(8)
   ) u_small (
      .clk(clk), .rst(rst), .en(s_en), .restart(s_restart),
      .seed_we(s_seed_we), .seed_sel(s_seed_sel), .seed_data(s_seed_data),
      .gc_bit(s_gc), .stage_msb(s_msb), .out_data(s_out_data),
      .out_valid(s_out_valid), .out_ready(s_out_ready)
   );

   gollmann_cascade_param u_dflt (
      .clk(clk), .rst(rst), .en(d_en), .restart(d_restart),
      .seed_we(d_seed_we), .seed_sel(d_seed_sel), .seed_data(d_seed_data),
      .gc_bit(d_gc), .stage_msb(d_msb), .out_data(d_out_data),
      .out_valid(d_out_valid), .out_ready(d_out_ready)
   );

   task automatic check_value(input string tag, input logic [63:0] got,
                              input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   // Apply n advances to the small instance. Before each edge, check
   // gc_bit against the table.
   task automatic s_adv(input int n);
      for (int i = 0; i < n; i++) begin
         check_value("s_gc_step", 64'(s_gc), 64'(gc_tab[sidx]));
         s_en = 1'b1;
         @(negedge clk);
         sidx = (sidx + 1) % 15;
      end
      s_en = 1'b0;
   endtask

   // Pulse restart with en held high. No advance may happen in that cycle.
   task automatic s_restart_pulse();
      s_restart = 1'b1;
      s_en      = 1'b1;
      @(negedge clk);
      s_restart = 1'b0;
      s_en      = 1'b0;
      sidx      = 0;
   endtask

   initial begin
      rst = 1'b1;
      s_en = 0; s_restart = 0; s_seed_we = 0; s_out_ready = 0;
      s_seed_sel = '0; s_seed_data = '0;
      d_en = 0; d_restart = 0; d_seed_we = 0; d_out_ready = 1;
      d_seed_sel = '0; d_seed_data = '0;

      // ---- reset state (checked while rst is held) ----
      repeat (2) @(negedge clk);
      check_value("rst_s_gc",    64'(s_gc), 64'd1);
      check_value("rst_s_msb",   64'(s_msb), 64'd0);
      check_value("rst_s_valid", 64'(s_out_valid), 64'd0);
      check_value("rst_s_data",  64'(s_out_data), 64'h00);
      check_value("rst_d_gc",    64'(d_gc), 64'd1);
      check_value("rst_d_msb",   64'(d_msb), 64'd0);
      check_value("rst_d_valid", 64'(d_out_valid), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // ---- free-running sequence with out_ready=1 ----
      s_out_ready = 1'b1;
      s_adv(8);
      check_value("seq_valid8", 64'(s_out_valid), 64'd1);
      check_value("seq_word8",  64'(s_out_data), 64'hEC);
      s_adv(1);
      check_value("seq_valid9", 64'(s_out_valid), 64'd0);
      s_adv(6);
      check_value("seq_wrap_gc",  64'(s_gc), 64'd1);
      check_value("seq_wrap_msb", 64'(s_msb), 64'd0);

      // ---- restart in the middle of a word ----
      s_restart_pulse();
      s_adv(5);
      s_restart_pulse();
      check_value("rs_gc",    64'(s_gc), 64'd1);
      check_value("rs_msb",   64'(s_msb), 64'd0);
      check_value("rs_valid", 64'(s_out_valid), 64'd0);
      s_adv(8);
      check_value("rs_valid8", 64'(s_out_valid), 64'd1);
      check_value("rs_word8",  64'(s_out_data), 64'hEC);

      // ---- backpressure ----
      s_restart_pulse();
      s_out_ready = 1'b0;
      s_adv(8);
      check_value("bp_valid8", 64'(s_out_valid), 64'd1);
      check_value("bp_word8",  64'(s_out_data), 64'hEC);
      s_adv(7);
      for (int i = 0; i < 4; i++) begin
         check_value("bp_hold_gc",    64'(s_gc), 64'd1);
         check_value("bp_hold_msb",   64'(s_msb), 64'd0);
         check_value("bp_hold_valid", 64'(s_out_valid), 64'd1);
         check_value("bp_hold_data",  64'(s_out_data), 64'hEC);
         s_en = 1'b1;
         @(negedge clk);
      end
      check_value("bp_stall_gc",   64'(s_gc), 64'd1);
      check_value("bp_stall_msb",  64'(s_msb), 64'd0);
      check_value("bp_stall_data", 64'(s_out_data), 64'hEC);
      s_out_ready = 1'b1;
      s_en = 1'b1;
      @(negedge clk);
      sidx = 1;
      s_en = 1'b0;
      check_value("bp_zb_valid", 64'(s_out_valid), 64'd1);
      check_value("bp_zb_word",  64'(s_out_data), 64'hA1);
      @(negedge clk);
      check_value("bp_drain_valid", 64'(s_out_valid), 64'd0);

      // ---- zero-seed guard; seed write blocks the advance, packer kept ----
      s_restart_pulse();
      s_adv(3);
      check_value("sg_pre_msb", 64'(s_msb), 64'd1);
      s_seed_we = 1'b1; s_seed_sel = 1'b0; s_seed_data = 4'h0; s_en = 1'b1;
      @(negedge clk);
      s_seed_we = 1'b0; s_en = 1'b0;
      sidx = 0;
      check_value("sg_gc",  64'(s_gc), 64'd1);
      check_value("sg_msb", 64'(s_msb), 64'd0);
      s_adv(5);
      check_value("sg_valid", 64'(s_out_valid), 64'd1);
      check_value("sg_word",  64'(s_out_data), 64'hFD);

      // ---- seed_sel out of range is ignored ----
      s_seed_we = 1'b1; s_seed_sel = 1'b1; s_seed_data = 4'h8;
      @(negedge clk);
      s_seed_we = 1'b0;
      check_value("oor_msb", 64'(s_msb), 64'd0);
      s_adv(2);

      // ---- cascade: stage 1 holds while m_0=1 and steps when m_0=0 ----
      d_seed_we = 1'b1; d_seed_sel = 2'd0; d_seed_data = 32'h8000_0000;
      @(negedge clk);
      d_seed_sel = 2'd1; d_seed_data = 32'h4000_0000;
      @(negedge clk);
      d_seed_we = 1'b0;
      check_value("cas_seed_msb", 64'(d_msb), 64'b001);
      check_value("cas_seed_gc",  64'(d_gc), 64'd0);
      d_en = 1'b1;
      @(negedge clk);
      d_en = 1'b0;
      check_value("cas_hold_msb", 64'(d_msb), 64'b000);
      check_value("cas_hold_gc",  64'(d_gc), 64'd1);
      d_en = 1'b1;
      @(negedge clk);
      d_en = 1'b0;
      check_value("cas_step_msb", 64'(d_msb), 64'b010);
      check_value("cas_step_gc",  64'(d_gc), 64'd0);
      d_seed_we = 1'b1; d_seed_sel = 2'd3; d_seed_data = 32'hFFFF_FFFF;
      @(negedge clk);
      d_seed_we = 1'b0;
      check_value("cas_oor_msb", 64'(d_msb), 64'b010);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
